reg_file_mrw: RTL

- Parametrised multi-read-port register file with one write port.
- Successor to the fixed 32-input read selector: generalised in width, depth and read-port count.
- Adds clocked storage, selectable registered reads, write-to-read bypass and a hardwired zero register.
- Sits between decode (addresses) and execute (operands) in the datapath.

---
 rtl/reg_file_mrw_pkg.sv | 13 +
 rtl/reg_read_mux.sv | 23 ++
 rtl/reg_file_mrw.sv | 112 +++++++++++
 3 files changed

// File: rtl/reg_file_mrw_pkg.sv
// Shared constants and helpers for the multi-read-port register file.
package reg_file_mrw_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultDepth = 32;
    localparam int unsigned ZeroAddr     = 0;

    // Address width for a given depth, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 32'd1) ? 32'($clog2(depth)) : 32'd1;
    endfunction

endpackage

// File: rtl/reg_read_mux.sv
// DEPTH-to-1 selector over a flattened register array.
module reg_read_mux
    import reg_file_mrw_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned DEPTH  = DefaultDepth,
    localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] data_i,
    input  logic [ADDR_W-1:0]      sel_i,
    output logic [WIDTH-1:0]       data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_i == ADDR_W'(i)) begin
                data_o = data_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/reg_file_mrw.sv
// Parametrised register file: one write port, N_RD read ports with optional
// registered reads, write-to-read bypass and a hardwired zero register.
module reg_file_mrw
    import reg_file_mrw_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned DEPTH    = DefaultDepth,
    parameter int unsigned N_RD     = 2,
    parameter bit          READ_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W  = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [N_RD-1:0]        re,
    input  logic [N_RD*ADDR_W-1:0] raddr,
    output logic [N_RD*WIDTH-1:0]  rdata,
    output logic [N_RD-1:0]        rvalid
);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic                   wr_zero;

    assign wr_zero = ZERO_REG && (waddr == ADDR_W'(ZeroAddr));

    always_comb begin
        mem_d = mem_q;
        if (we && !wr_zero) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  stored;
        logic [WIDTH-1:0]  fwd;

        assign addr = raddr[p*ADDR_W +: ADDR_W];

        reg_read_mux #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_mux (
            .data_i (mem_flat),
            .sel_i  (addr),
            .data_o (stored)
        );

        // Zero forcing is applied last so it overrides a bypass hit on address 0.
        always_comb begin
            fwd = stored;
            if (BYPASS && we && (waddr == addr)) begin
                fwd = wdata;
            end
            if (ZERO_REG && (addr == ADDR_W'(ZeroAddr))) begin
                fwd = '0;
            end
        end

        if (READ_REG) begin : g_reg
            logic [WIDTH-1:0] rdata_q, rdata_d;
            logic             rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = re[p] ? fwd : rdata_q;
                rvalid_d = re[p];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata[p*WIDTH +: WIDTH] = rdata_q;
            assign rvalid[p]               = rvalid_q;
        end else begin : g_comb
            logic unused_re;
            assign unused_re               = re[p];
            assign rdata[p*WIDTH +: WIDTH] = fwd;
            assign rvalid[p]               = 1'b1;
        end
    end

endmodule
